uf_add_seq: RTL and testbench

UF_ADD_SEQ -- requirements
Module: uf_add_seq

---
 rtl/uf_add_seq.sv | 144 ++++++++++++++
 tb/tb_uf_add_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uf_add_seq.sv
// rtl/uf_add_seq.sv - sequential adder for unsigned minifloats {exp, 1.mant}
// Walks IDLE -> ALIGN -> ADD -> NORM -> DONE with a valid/ready handshake on each side.
module uf_add_seq #(
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW-1:0] a,
  input  logic [EW+MW-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW-1:0] c,
  output logic             ovf
);

  localparam int SW = MW + 2;
  localparam int CW = $clog2(MW + 3);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       e_big_q, e_big_d;
  logic [SW-1:0]       big_q, big_d;
  logic [SW-1:0]       small_q, small_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW:0]         sum_q, sum_d;
  logic [EW+MW-1:0]    c_q, c_d;
  logic                ovf_q, ovf_d;

  logic [EW-1:0]       ea, eb, diff;
  logic                a_big;
  logic [31:0]         diff_w;
  logic [CW-1:0]       cnt_init;
  logic [SW-1:0]       sig_a, sig_b;

  assign ea       = a[EW+MW-1:MW];
  assign eb       = b[EW+MW-1:MW];
  assign a_big    = (ea >= eb);
  assign diff     = a_big ? (ea - eb) : (eb - ea);
  assign diff_w   = 32'(diff);
  // Shifting further than the significand width leaves zero, so cap the count.
  assign cnt_init = (diff_w > 32'(SW)) ? CW'(SW) : CW'(diff_w);
  assign sig_a    = {1'b1, a[MW-1:0], 1'b0};
  assign sig_b    = {1'b1, b[MW-1:0], 1'b0};

  logic                msb;
  logic [MW-1:0]       field_pre, field_fin;
  logic                guard;
  logic [EW:0]         exp_pre, exp_fin;
  logic [MW:0]         rnd;
  logic                norm_ovf;
  logic [EW+MW-1:0]    norm_c;

  assign msb = sum_q[SW];

  always_comb begin
    field_pre = msb ? sum_q[MW+1:2] : sum_q[MW:1];
    guard     = msb ? sum_q[1] : sum_q[0];
    exp_pre   = {1'b0, e_big_q} + {{EW{1'b0}}, msb};
    rnd       = {1'b0, field_pre} + {{MW{1'b0}}, guard};
    field_fin = rnd[MW-1:0];
    exp_fin   = exp_pre;
    if (rnd[MW]) begin
      field_fin = '0;
      exp_fin   = exp_pre + (EW+1)'(1);
    end
    norm_ovf = exp_fin[EW];
    norm_c   = norm_ovf ? '1 : {exp_fin[EW-1:0], field_fin};
  end

  always_comb begin
    state_d = state_q;
    e_big_d = e_big_q;
    big_d   = big_q;
    small_d = small_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          e_big_d = a_big ? ea : eb;
          big_d   = a_big ? sig_a : sig_b;
          small_d = a_big ? sig_b : sig_a;
          cnt_d   = cnt_init;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt_q != '0) begin
          small_d = small_q >> 1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = {1'b0, big_q} + {1'b0, small_q};
        state_d = NORM;
      end
      NORM: begin
        c_d     = norm_c;
        ovf_d   = norm_ovf;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_big_q <= '0;
      big_q   <= '0;
      small_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_big_q <= e_big_d;
      big_q   <= big_d;
      small_q <= small_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_uf_add_seq.sv
// tb/tb_uf_add_seq.sv - randomized and directed checks of uf_add_seq against a value-level model
// A negedge checker tracks every transaction; directed ops pin latency and literal results.
module tb_uf_add_seq;

  localparam int EW = 3;
  localparam int MW = 4;
  localparam int W  = EW + MW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] c;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uf_add_seq #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Exact sum on scaled integers, truncating the small operand as it is shifted, then round half-up.
  function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] rc, output logic ro, output int rd);
    int ex, ey, mx, my, eb, sb, ss, sum, sh, e, f, g;
    ex = int'(x[W-1:MW]);
    ey = int'(y[W-1:MW]);
    mx = int'(x[MW-1:0]);
    my = int'(y[MW-1:0]);
    if (ex >= ey) begin
      eb = ex; sb = (2**MW + mx) * 2; ss = (2**MW + my) * 2; rd = ex - ey;
    end else begin
      eb = ey; sb = (2**MW + my) * 2; ss = (2**MW + mx) * 2; rd = ey - ex;
    end
    if (rd > MW + 2) rd = MW + 2;
    ss  = ss >> rd;
    sum = sb + ss;
    sh  = (sum >= 2**(MW+2)) ? 2 : 1;
    e   = eb + sh - 1;
    f   = (sum >> sh) % (2**MW);
    g   = (sum >> (sh - 1)) % 2;
    f   = f + g;
    if (f == 2**MW) begin
      f = 0;
      e = e + 1;
    end
    if (e > 2**EW - 1) begin
      rc = '1;
      ro = 1'b1;
    end else begin
      rc = W'(e * 2**MW + f);
      ro = 1'b0;
    end
  endfunction

  int           cyc = 0;
  int           due = 0;
  bit           busy = 1'b0;
  bit           exp_vld;
  logic [W-1:0] mc;
  logic         mo;
  int           md;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_c", 32'(c), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));
    end else begin
      exp_vld = busy && (cyc >= due);
      check("in_ready", 32'(in_ready), 32'(!busy));
      check("out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
        check("c", 32'(c), 32'(mc));
        check("ovf", 32'(ovf), 32'(mo));
        if (out_ready) busy = 1'b0;
      end else if (!busy && in_valid) begin
        ref_add(a, b, mc, mo, md);
        busy = 1'b1;
        due  = cyc + md + 4;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] ec,
                        input logic eo, input int elat, input int hold, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_start_ready"}, 32'(in_ready), 32'(1));
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, 32'(n), 32'(elat));
    check({name, "_c"}, 32'(c), 32'(ec));
    check({name, "_ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_c"}, 32'(c), 32'(ec));
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'(0));
      check({name, "_hold_out_valid"}, 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_after_in_ready"}, 32'(in_ready), 32'(1));
    check({name, "_after_out_valid"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    int n;
    logic [EW-1:0] ex;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(7'b101_1000, 7'b101_1000, 7'b110_1000, 1'b0, 3, 0, "equal_exp");
    run_op(7'b100_0000, 7'b010_0000, 7'b100_0100, 1'b0, 5, 0, "align");
    run_op(7'b101_1111, 7'b000_0000, 7'b110_0000, 1'b0, 8, 5, "round_carry_bp");
    run_op(7'b111_1111, 7'b111_1111, 7'b111_1111, 1'b1, 3, 0, "overflow");
    run_op(7'b111_0000, 7'b000_0000, 7'b111_0000, 1'b0, 9, 0, "shift_cap");

    for (int i = 0; i < 600; i++) begin
      a  = W'($urandom);
      ex = EW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? {a[W-1:MW], MW'($urandom)} : {ex, MW'($urandom)};
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("drain_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b0;

    a = 7'b111_0000; b = 7'b000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midalign_rst_out_valid", 32'(out_valid), 32'(0));
    check("midalign_rst_in_ready", 32'(in_ready), 32'(1));
    check("midalign_rst_c", 32'(c), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(7'b100_0000, 7'b010_0000, 7'b100_0100, 1'b0, 5, 0, "post_reset");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
